// File: rtl/riscv_pkg.sv
// Shared RV32I load/store funct3 encodings and the data-memory responder state type.
package riscv_pkg;

    localparam logic [2:0] Funct3B  = 3'b000;
    localparam logic [2:0] Funct3H  = 3'b001;
    localparam logic [2:0] Funct3W  = 3'b010;
    localparam logic [2:0] Funct3Bu = 3'b100;
    localparam logic [2:0] Funct3Hu = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } rsp_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: store byte-lane merge, load lane extraction/extension and
// misalignment / illegal-funct3 detection.
module dmem_lane_align
    import riscv_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [31:0] new_word,
    output logic [31:0] load_data,
    output logic        err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  be;
    logic [31:0] wrep;

    assign byte_sel = old_word[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? old_word[31:16] : old_word[15:0];

    always_comb begin
        err       = 1'b0;
        load_data = 32'h0;
        be        = 4'b0000;
        wrep      = 32'h0;
        case (funct3)
            Funct3B: begin
                load_data = {{24{byte_sel[7]}}, byte_sel};
                be        = 4'b0001 << addr_lo;
                wrep      = {4{wdata[7:0]}};
            end
            Funct3H: begin
                err       = addr_lo[0];
                load_data = {{16{half_sel[15]}}, half_sel};
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wrep      = {2{wdata[15:0]}};
            end
            Funct3W: begin
                err       = (addr_lo != 2'b00);
                load_data = old_word;
                be        = 4'b1111;
                wrep      = wdata;
            end
            // Unsigned variants exist only for loads.
            Funct3Bu: begin
                err       = we;
                load_data = {24'h0, byte_sel};
            end
            Funct3Hu: begin
                err       = we | addr_lo[0];
                load_data = {16'h0, half_sel};
            end
            default: err = 1'b1;
        endcase
    end

    always_comb begin
        new_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) new_word[8*i +: 8] = wrep[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency RV32I data-memory responder: one outstanding request, response pulse
// LATENCY cycles after accept, pipeline stall while the access is in flight.
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall_m
);

    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    localparam logic [2:0]  CntInit = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    rsp_state_e        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [AW+1:0]     addr_q;
    logic [31:0]       wdata_q;
    logic              accept;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [AW-1:0]     idx;
    logic [31:0]       rd_word;
    logic [31:0]       new_word;
    logic [31:0]       load_data;
    logic              err;

    // Upper address bits alias onto the array.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:AW+2];

    assign req_ready = (state_q == StIdle);
    assign accept    = req_valid & req_ready;
    assign stall_m   = (req_valid & (state_q == StIdle)) | (state_q == StWait);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) state_d = StResp;
                else               cnt_d   = cnt_q - 3'd1;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr[AW+1:0];
                wdata_q  <= req_wdata;
            end
        end
    end

    assign idx     = addr_q[AW+1:2];
    assign rd_word = mem[idx];

    dmem_lane_align u_lane_align (
        .we        (we_q),
        .funct3    (funct3_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .old_word  (rd_word),
        .new_word  (new_word),
        .load_data (load_data),
        .err       (err)
    );

    // Store commits on the edge that ends RESP; reset clears state so an abandoned
    // request never reaches this point.
    always_ff @(posedge clk) begin
        if ((state_q == StResp) && we_q && !err) mem[idx] <= new_word;
    end

    assign rsp_valid = (state_q == StResp);
    assign rsp_err   = rsp_valid & err;
    assign rsp_rdata = (rsp_valid && !err && !we_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 2 (main), 1 and 7.
module tb_dmem_responder;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;
    localparam logic [2:0] F_BAD = 3'b011;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_we     [3];
    logic [2:0]  req_funct3 [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        rsp_valid  [3];
    logic [31:0] rsp_rdata  [3];
    logic        rsp_err    [3];
    logic        stall_m    [3];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .stall_m(stall_m[0])
    );

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .stall_m(stall_m[1])
    );

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(7)) u_dut_l7 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_funct3(req_funct3[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]),
        .stall_m(stall_m[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction on instance d, checking timing, stall, ready and response.
    task automatic xact(input int d, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input string tag);
        int          lat;
        int          stalls;
        int          readys;
        logic        got;
        logic [31:0] rdata;
        logic        err;
        @(negedge clk);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        #1;
        check_eq({tag, "/ready"}, 32'(req_ready[d]), 32'd1);
        stalls = stall_m[d] ? 1 : 0;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        lat = 0; readys = 0; got = 1'b0; rdata = 32'h0; err = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (stall_m[d])   stalls++;
            if (req_ready[d]) readys++;
            if (rsp_valid[d]) begin
                got   = 1'b1;
                rdata = rsp_rdata[d];
                err   = rsp_err[d];
            end
        end
        check_eq({tag, "/lat"},    32'(lat),    32'(exp_lat));
        check_eq({tag, "/stall"},  32'(stalls), 32'(exp_lat));
        check_eq({tag, "/busy"},   32'(readys), 32'd0);
        check_eq({tag, "/rdata"},  rdata,       exp_rdata);
        check_eq({tag, "/err"},    32'(err),    32'(exp_err));
        @(negedge clk);
        check_eq({tag, "/idle"}, {rsp_rdata[d][29:0], rsp_valid[d], rsp_err[d]}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rsp_seen;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_funct3[i] = 3'd0;
            req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
        end
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst/rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check_eq("rst/rsp_rdata", rsp_rdata[0],       32'h0);
        check_eq("rst/rsp_err",   32'(rsp_err[0]),   32'd0);
        check_eq("rst/req_ready", 32'(req_ready[0]), 32'd1);
        check_eq("rst/stall_m",   32'(stall_m[0]),   32'd0);
        reset_n = 1'b1;

        // Store then load same address.
        xact(0, 1'b1, F_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, "sw10");
        xact(0, 1'b0, F_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, "lw10");

        // Lane extraction and extension.
        xact(0, 1'b1, F_W,  32'h20, 32'h80817F80, 32'h0, 1'b0, 2, "sw20");
        xact(0, 1'b0, F_B,  32'h20, 32'h0, 32'hFFFFFF80, 1'b0, 2, "lb20");
        xact(0, 1'b0, F_BU, 32'h23, 32'h0, 32'h00000080, 1'b0, 2, "lbu23");
        xact(0, 1'b0, F_H,  32'h22, 32'h0, 32'hFFFF8081, 1'b0, 2, "lh22");
        xact(0, 1'b0, F_HU, 32'h20, 32'h0, 32'h00007F80, 1'b0, 2, "lhu20");
        xact(0, 1'b0, F_B,  32'h21, 32'h0, 32'h0000007F, 1'b0, 2, "lb21");

        // Byte store merge.
        xact(0, 1'b1, F_W, 32'h30, 32'h11223344, 32'h0, 1'b0, 2, "sw30");
        xact(0, 1'b1, F_B, 32'h31, 32'h555555AB, 32'h0, 1'b0, 2, "sb31");
        xact(0, 1'b0, F_W, 32'h30, 32'h0, 32'h1122AB44, 1'b0, 2, "lw30");

        // Misalignment and illegal encodings.
        xact(0, 1'b1, F_W,   32'h44, 32'hCAFEF00D, 32'h0, 1'b0, 2, "sw44");
        xact(0, 1'b0, F_W,   32'h42, 32'h0, 32'h0, 1'b1, 2, "lw42");
        xact(0, 1'b1, F_H,   32'h45, 32'h00001234, 32'h0, 1'b1, 2, "sh45");
        xact(0, 1'b1, F_BU,  32'h44, 32'h000000EE, 32'h0, 1'b1, 2, "sbu44");
        xact(0, 1'b0, F_BAD, 32'h44, 32'h0, 32'h0, 1'b1, 2, "f011");
        xact(0, 1'b0, F_W,   32'h44, 32'h0, 32'hCAFEF00D, 1'b0, 2, "lw44a");
        xact(0, 1'b1, F_H,   32'h46, 32'hFFFF1234, 32'h0, 1'b0, 2, "sh46");
        xact(0, 1'b0, F_W,   32'h44, 32'h0, 32'h1234F00D, 1'b0, 2, "lw44b");

        // Address wrap-around.
        xact(0, 1'b1, F_W, 32'h1000, 32'h5, 32'h0, 1'b0, 2, "sw1000");
        xact(0, 1'b0, F_W, 32'h0, 32'h0, 32'h5, 1'b0, 2, "lw0");

        // Reset during WAIT abandons the store.
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = F_W;
        req_addr[0] = 32'h0; req_wdata[0] = 32'h9;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check_eq("rstwait/stall", 32'(stall_m[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("rstwait/ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        rsp_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid[0]) rsp_seen++;
        end
        check_eq("rstwait/no_rsp", 32'(rsp_seen), 32'd0);
        xact(0, 1'b0, F_W, 32'h0, 32'h0, 32'h5, 1'b0, 2, "lw0_after");

        // Other latencies.
        xact(1, 1'b1, F_W, 32'h8, 32'h0BADCAFE, 32'h0, 1'b0, 1, "l1_sw");
        xact(1, 1'b0, F_W, 32'h8, 32'h0, 32'h0BADCAFE, 1'b0, 1, "l1_lw");
        xact(2, 1'b1, F_W, 32'h8, 32'h13579BDF, 32'h0, 1'b0, 7, "l7_sw");
        xact(2, 1'b0, F_H, 32'hA, 32'h0, 32'h00001357, 1'b0, 7, "l7_lh");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
